// File: rtl/store_trace_capture.sv
// store_trace_capture
// Sits on the SoC data-memory write port. Stores that land inside
// [Window_Base, Window_Limit] are queued in a first-word-fall-through FIFO
// for a downstream consumer, and the store to Term_Addr latches a sticky
// PASS/FAIL verdict.
//
// Optional feature: define STORE_TRACE_DROP_COUNT_EN to add o_Drop_Count, a
// saturating 16-bit count of in-window stores dropped while the FIFO was full.
//
// Handshake: o_Trace_Valid/i_Trace_Ready follow strict valid/ready rules.
// The head entry (o_Trace_Address/o_Trace_Data) is held stable while valid is
// high and ready is low. A transfer happens on any rising edge where both are
// high. Valid never depends on ready. Ready is ignored while valid is low.
//
// o_Dbg_State exposes the verdict FSM state: 0 = RUN, 1 = PASS, 2 = FAIL.
module store_trace_capture #(
  parameter int unsigned          BusWidth     = 32,
  parameter int unsigned          Depth        = 8,
  parameter logic [BusWidth-1:0]  Window_Base  = 0,
  parameter logic [BusWidth-1:0]  Window_Limit = 255,
  parameter logic [BusWidth-1:0]  Term_Addr    = 100,
  parameter logic [BusWidth-1:0]  Term_Data    = 7
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET,
  input  logic                        i_Mem_Write,
  input  logic [BusWidth-1:0]         i_Address,
  input  logic [BusWidth-1:0]         i_Write_Data,
  output logic                        o_Trace_Valid,
  input  logic                        i_Trace_Ready,
  output logic [BusWidth-1:0]         o_Trace_Address,
  output logic [BusWidth-1:0]         o_Trace_Data,
  output logic [$clog2(Depth):0]      o_Count,
  output logic                        o_Full,
  output logic                        o_Empty,
  output logic                        o_Overflow,
  output logic                        o_Done,
  output logic                        o_Pass,
`ifdef STORE_TRACE_DROP_COUNT_EN
  output logic [15:0]                 o_Drop_Count,
`endif
  output logic [1:0]                  o_Dbg_State
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(Depth);
  // Window span; the address check subtracts the base so a single unsigned
  // compare covers both bounds.
  localparam logic [BusWidth-1:0] WINDOW_SPAN = Window_Limit - Window_Base;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [BusWidth-1:0] store_addr [Depth];
  logic [BusWidth-1:0] store_data [Depth];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                overflow;

  logic                in_window;
  logic                is_term;
  logic                hit;
  logic                pop;
  logic                push;
  logic                drop;

  // Classify this cycle's store and decide push / pop / drop.
  always_comb begin
    in_window = (i_Address - Window_Base) <= WINDOW_SPAN;
    is_term   = i_Mem_Write && (i_Address == Term_Addr);
    hit       = i_Mem_Write && in_window && (state == RUN);
    pop       = o_Trace_Valid && i_Trace_Ready;
    push      = hit && (!o_Full || pop);
    drop      = hit && o_Full && !pop;
  end

  // Verdict next-state: only the first terminal store while running counts.
  always_comb begin
    state_next = state;
    if (state == RUN && is_term) begin
      state_next = (i_Write_Data == Term_Data) ? PASS : FAIL;
    end
  end

  // Verdict state register.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) state <= RUN;
    else         state <= state_next;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      store_addr[wr_ptr] <= i_Address;
      store_data[wr_ptr] <= i_Write_Data;
    end
  end

`ifdef STORE_TRACE_DROP_COUNT_EN
  logic [15:0] drop_count;

  // Saturating count of dropped in-window stores.
  always_ff @(posedge i_CLK) begin
    if (i_RESET)                        drop_count <= '0;
    else if (drop && drop_count != '1)  drop_count <= drop_count + 16'd1;
  end

  assign o_Drop_Count = drop_count;
`endif

  assign o_Count         = count;
  assign o_Full          = (count == FULL_COUNT);
  assign o_Empty         = (count == '0);
  assign o_Trace_Valid   = !o_Empty;
  assign o_Trace_Address = store_addr[rd_ptr];
  assign o_Trace_Data    = store_data[rd_ptr];
  assign o_Overflow      = overflow;
  assign o_Done          = (state != RUN);
  assign o_Pass          = (state == PASS);
  assign o_Dbg_State     = state;

endmodule

// File: tb/tb_store_trace_capture.sv
// tb_store_trace_capture
// Directed and randomized stimulus for store_trace_capture, checked each
// cycle against a queue-based reference model of the capture and verdict.
module tb_store_trace_capture;

  localparam int          W     = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] WB    = 32'd0;
  localparam logic [31:0] WL    = 32'd255;
  localparam logic [31:0] TA    = 32'd100;
  localparam logic [31:0] TD    = 32'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mem_write;
  logic [W-1:0]  address;
  logic [W-1:0]  write_data;
  logic          trace_ready;
  logic          trace_valid;
  logic [W-1:0]  trace_address;
  logic [W-1:0]  trace_data;
  logic [$clog2(DEPTH):0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          done;
  logic          pass;
  logic [1:0]    dbg_state;
`ifdef STORE_TRACE_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  store_trace_capture #(
    .BusWidth(W), .Depth(DEPTH), .Window_Base(WB), .Window_Limit(WL),
    .Term_Addr(TA), .Term_Data(TD)
  ) dut (
    .i_CLK(clk),
    .i_RESET(rst),
    .i_Mem_Write(mem_write),
    .i_Address(address),
    .i_Write_Data(write_data),
    .o_Trace_Valid(trace_valid),
    .i_Trace_Ready(trace_ready),
    .o_Trace_Address(trace_address),
    .o_Trace_Data(trace_data),
    .o_Count(count),
    .o_Full(full),
    .o_Empty(empty),
    .o_Overflow(overflow),
    .o_Done(done),
    .o_Pass(pass),
`ifdef STORE_TRACE_DROP_COUNT_EN
    .o_Drop_Count(drop_count),
`endif
    .o_Dbg_State(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];     // expected data, in order
  logic [W-1:0] exp_aq[$];    // expected addresses, in order
  bit           m_overflow;
  int           m_verdict;    // 0 none yet, 1 pass, 2 fail
  int           m_drops;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(count),    32'(exp_q.size()));
    check({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
    check({tag, ".valid"},    32'(trace_valid), 32'(exp_q.size() != 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_overflow));
    check({tag, ".done"},     32'(done),     32'(m_verdict != 0));
    check({tag, ".pass"},     32'(pass),     32'(m_verdict == 1));
    if (exp_q.size() != 0) begin
      check({tag, ".head_addr"}, trace_address, exp_aq[0]);
      check({tag, ".head_data"}, trace_data,    exp_q[0]);
    end
`ifdef STORE_TRACE_DROP_COUNT_EN
    check({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0; trace_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete(); exp_aq.delete();
    m_overflow = 0; m_verdict = 0; m_drops = 0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: apply a store (or idle) and ready, update model, check.
  task automatic step(input string tag, input bit we, input logic [W-1:0] a,
                      input logic [W-1:0] d, input bit rdy);
    bit popped, hit, was_full;
    @(negedge clk);
    mem_write = we; address = a; write_data = d; trace_ready = rdy;
    popped   = rdy && (exp_q.size() > 0);
    was_full = (exp_q.size() == DEPTH);
    hit      = we && (a >= WB) && (a <= WL) && (m_verdict == 0);
    @(posedge clk); #1;
    if (popped) begin
      void'(exp_q.pop_front());
      void'(exp_aq.pop_front());
    end
    if (hit) begin
      if (!was_full || popped) begin
        exp_q.push_back(d);
        exp_aq.push_back(a);
      end else begin
        m_overflow = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (m_verdict == 0 && we && a == TA) m_verdict = (d == TD) ? 1 : 2;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] rand_addr(input int unsigned hi);
    logic [W-1:0] a;
    a = W'($urandom_range(0, hi));
    if (a == TA) a = TA + 1;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; mem_write = 1'b0; address = '0; write_data = '0; trace_ready = 1'b0;
    m_overflow = 0; m_verdict = 0; m_drops = 0;

    do_reset("reset");

    // Three stores held, then drained in order.
    step("st4",  1, 32'd4,  32'd11, 0);
    step("st8",  1, 32'd8,  32'd22, 0);
    step("st12", 1, 32'd12, 32'd33, 0);
    for (int i = 0; i < 3; i++) step("drain3", 0, '0, '0, 1);
    step("pop_empty", 0, '0, '0, 1);

    // Out-of-window store and window edges.
    step("out300", 1, 32'd300, 32'd1, 0);
    step("edge0",   1, 32'd0,   32'hA0, 0);
    step("edge255", 1, 32'd255, 32'hA1, 0);
    step("edge256", 1, 32'd256, 32'hA2, 0);

    // Fill to full, push+pop at full, then a dropped store.
    do_reset("reset2");
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1, rand_addr(255), W'($urandom), 0);
    step("full_pushpop", 1, rand_addr(255), W'($urandom), 1);
    step("drop",         1, rand_addr(255), W'($urandom), 0);
    step("drop2",        1, rand_addr(255), W'($urandom), 0);
    for (int i = 0; i < DEPTH; i++) step("drain_full", 0, '0, '0, 1);

    // Randomized mix of stores, idles and ready.
    for (int i = 0; i < 150; i++)
      step("rand", 1'($urandom_range(0, 1)), rand_addr(400), W'($urandom),
           1'($urandom_range(0, 1)));

    // Terminal store with matching data, then a later mismatching one.
    do_reset("reset3");
    step("pre_term", 1, 32'd50, 32'd3, 0);
    step("term_pass", 1, TA, TD, 0);
    step("term_again", 1, TA, 32'd5, 0);
    step("frozen", 1, 32'd60, 32'd4, 0);
    for (int i = 0; i < 20; i++)
      step("post_pass", 1'($urandom_range(0, 1)), rand_addr(255), W'($urandom),
           1'($urandom_range(0, 1)));

    // Terminal store with wrong data, then reset resumes capture.
    do_reset("reset4");
    step("term_fail", 1, TA, 32'd9, 0);
    step("fail_hold", 1, TA, TD, 1);
    do_reset("reset5");
    step("resume", 1, 32'd20, 32'd5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
